// File: rtl/column_byte_reader.sv
// column_byte_reader: captures a 4-byte column, optionally applying RotWord, and streams it out one byte per handshake.
// Defining COLUMN_READER_INV_ROT_EN adds an inv_rot input that rotates the column right by one byte on capture.
module column_byte_reader (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic [7:0] in4,
    input  logic       load,
    input  logic       rot,
`ifdef COLUMN_READER_INV_ROT_EN
    input  logic       inv_rot,
`endif
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       out_valid,
    output logic [1:0] out_index,
    output logic       out_last,
    output logic       busy,
    output logic       done
);
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
    state_t          state_q, state_d;
    logic [3:0][7:0] store_q, store_d, cap;
    logic [1:0]      idx_q, idx_d;
    logic            done_q, done_d;
    logic            accept, xfer, final_xfer;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            store_q <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end
    // Element 0 of cap is row 0; rot wins over inv_rot when both are set.
    always_comb begin
`ifdef COLUMN_READER_INV_ROT_EN
        cap = rot ? {in1, in4, in3, in2} : inv_rot ? {in3, in2, in1, in4} : {in4, in3, in2, in1};
`else
        cap = rot ? {in1, in4, in3, in2} : {in4, in3, in2, in1};
`endif
    end
    assign accept     = (state_q == IDLE) && load;
    assign xfer       = (state_q == SEND) && out_ready;
    assign final_xfer = xfer && (idx_q == 2'd3);
    always_comb begin
        state_d = accept ? SEND : final_xfer ? IDLE : state_q;
    end
    // The index wraps from 3 back to 0 on the final transfer.
    always_comb begin
        store_d = accept ? cap : store_q;
        idx_d   = accept ? 2'd0 : xfer ? idx_q + 2'd1 : idx_q;
        done_d  = final_xfer;
    end
    always_comb begin
        busy      = (state_q == SEND);
        out_valid = (state_q == SEND);
        out_index = idx_q;
        out_byte  = store_q[idx_q];
        out_last  = (state_q == SEND) && (idx_q == 2'd3);
        done      = done_q;
    end
endmodule

// File: tb/tb_column_byte_reader.sv
// tb_column_byte_reader: scoreboard-driven bench; expected bytes are queued at load and popped on each handshake.
module tb_column_byte_reader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0;
    logic       load = 1'b0, rot = 1'b0, inv_rot = 1'b0, out_ready = 1'b0;
    logic [7:0] out_byte;
    logic       out_valid, out_last, busy, done;
    logic [1:0] out_index;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];

    column_byte_reader dut (
        .clk(clk), .rst(rst),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .load(load), .rot(rot),
`ifdef COLUMN_READER_INV_ROT_EN
        .inv_rot(inv_rot),
`endif
        .out_ready(out_ready),
        .out_byte(out_byte), .out_valid(out_valid), .out_index(out_index),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [7:0] a, b, c, d, input logic r, input logic ir);
        logic [7:0] v[4];
        int j;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int k = 0; k < 4; k++) begin
            j = r ? (k + 1) % 4 : ir ? (k + 3) % 4 : k;
            exp_q.push_back(v[j]);
        end
    endtask

    task automatic do_load(input logic [7:0] a, b, c, d, input logic r, input logic ir);
        in1 = a; in2 = b; in3 = c; in4 = d;
        rot = r; inv_rot = ir; load = 1'b1;
        push_exp(a, b, c, d, r, ir);
        @(posedge clk); #1;
        load = 1'b0; rot = 1'b0; inv_rot = 1'b0;
    endtask

    task automatic test_reset;
        in1 = 8'h5a; in2 = 8'h5a; in3 = 8'h5a; in4 = 8'h5a;
        #2 rst = 1'b0;
        #1;
        checks++; if (out_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h want 00", out_byte); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_index !== 2'd0) begin errors++; $display("FAIL reset_index: got %0d want 0", out_index); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_stream(input string nm, input logic [7:0] a, b, c, d, input logic r, input logic ir);
        logic [7:0] e, first;
        out_ready = 1'b1;
        do_load(a, b, c, d, r, ir);
        first = exp_q[0];
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            checks++;
            if ({out_valid, busy, out_last, out_index, out_byte} !== {1'b1, 1'b1, (i == 3), 2'(i), e}) begin
                errors++;
                $display("FAIL %s beat%0d: got v=%b busy=%b last=%b idx=%0d byte=%h want v=1 busy=1 last=%b idx=%0d byte=%h",
                         nm, i, out_valid, busy, out_last, out_index, out_byte, (i == 3), i, e);
            end
            @(posedge clk); #1;
        end
        checks++;
        if ({done, busy, out_valid} !== 3'b100) begin
            errors++; $display("FAIL %s done_cycle: got done=%b busy=%b v=%b want 1 0 0", nm, done, busy, out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if ({done, out_index, out_byte} !== {1'b0, 2'd0, first}) begin
            errors++; $display("FAIL %s idle: got done=%b idx=%0d byte=%h want 0 0 %h", nm, done, out_index, out_byte, first);
        end
    endtask

    task automatic test_stall;
        int got = 0, stalls = 0, cyc = 0;
        logic [7:0] e;
        out_ready = 1'b1;
        do_load(8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 1'b0);
        while (got < 4 && cyc < 12) begin
            checks++;
            if ({out_valid, out_index, out_byte} !== {1'b1, 2'(got), exp_q[0]}) begin
                errors++;
                $display("FAIL stall beat%0d: got v=%b idx=%0d byte=%h want v=1 idx=%0d byte=%h",
                         got, out_valid, out_index, out_byte, got, exp_q[0]);
            end
            if (got == 1 && stalls < 2) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
                e = exp_q.pop_front();
                got++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        checks++; if (got != 4) begin errors++; $display("FAIL stall_timeout: got %0d beats want 4", got); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b want 1", done); end
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_load_ignored;
        logic [7:0] e;
        out_ready = 1'b1;
        do_load(8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            checks++;
            if ({out_index, out_byte} !== {2'(i), e}) begin
                errors++; $display("FAIL ignore beat%0d: got idx=%0d byte=%h want idx=%0d byte=%h", i, out_index, out_byte, i, e);
            end
            if (i == 2) begin
                in1 = 8'haa; in2 = 8'hbb; in3 = 8'hcc; in4 = 8'hdd; load = 1'b1;
            end else load = 1'b0;
            @(posedge clk); #1;
        end
        load = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ignore_done: got %b want 1", done); end
        @(posedge clk); #1;
        checks++;
        if ({busy, out_byte} !== {1'b0, 8'h01}) begin
            errors++; $display("FAIL ignore_store: got busy=%b byte=%h want busy=0 byte=01", busy, out_byte);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] e;
        out_ready = 1'b1;
        do_load(8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (out_byte !== e) begin errors++; $display("FAIL rstmid beat%0d: got %h want %h", i, out_byte, e); end
            @(posedge clk); #1;
        end
        checks++; if (out_index !== 2'd2) begin errors++; $display("FAIL rstmid_idx: got %0d want 2", out_index); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({out_byte, out_valid, out_index, out_last, busy, done} !== 14'd0) begin
            errors++;
            $display("FAIL rstmid_async: got byte=%h v=%b idx=%0d last=%b busy=%b done=%b want all 0",
                     out_byte, out_valid, out_index, out_last, busy, done);
        end
        @(posedge clk); #1;
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL rstmid_nodone: got done=%b busy=%b want 0 0", done, busy); end
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [7:0] e;
        out_ready = 1'b1;
        do_load(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (out_byte !== e) begin errors++; $display("FAIL b2b_a beat%0d: got %h want %h", i, out_byte, e); end
            if (i == 3) begin
                in1 = 8'h99; in2 = 8'h98; in3 = 8'h97; in4 = 8'h96; load = 1'b1;
            end
            @(posedge clk); #1;
        end
        load = 1'b0;
        checks++;
        if ({done, busy, out_byte} !== {1'b1, 1'b0, 8'h11}) begin
            errors++; $display("FAIL b2b_gap: got done=%b busy=%b byte=%h want 1 0 11", done, busy, out_byte);
        end
        do_load(8'h55, 8'h66, 8'h77, 8'h88, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            checks++;
            if ({out_valid, out_index, out_byte} !== {1'b1, 2'(i), e}) begin
                errors++; $display("FAIL b2b_b beat%0d: got v=%b idx=%0d byte=%h want v=1 idx=%0d byte=%h",
                                   i, out_valid, out_index, out_byte, i, e);
            end
            @(posedge clk); #1;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", done); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_stream("plain", 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 1'b0);
        test_stream("rot", 8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 1'b0);
        test_stall();
        test_load_ignored();
        test_reset_mid();
        test_stream("after_rst", 8'hc1, 8'hc2, 8'hc3, 8'hc4, 1'b0, 1'b0);
        test_back_to_back();
`ifdef COLUMN_READER_INV_ROT_EN
        test_stream("inv_rot", 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 1'b1);
        test_stream("rot_wins", 8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 1'b1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
